// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I widths, opcodes and fetch-stage types
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  typedef enum logic {RUN, HALT} fetch_state_t;
  function automatic logic word_aligned(input logic [1:0] lo);
    return lo == 2'b00;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small prefetch FIFO with registered head output and flush
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [PW:0] cnt_d;
  logic [WIDTH-1:0] head_d;
  // next storage and pointers; flush beats push so stale read data never enters
  always_comb begin
    mem_d = mem_q;
    if (push && !flush) mem_d[wptr_q] = din;
    rptr_d = flush ? '0 : rptr_q + PW'(pop);
    wptr_d = flush ? '0 : wptr_q + PW'(push);
    cnt_d = flush ? '0 : count + (PW+1)'(push) - (PW+1)'(pop);
    head_d = (cnt_d != '0) ? mem_d[rptr_d] : '0;
  end
  // storage, pointers, occupancy and the registered head (zero when empty)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
      rptr_q <= '0;
      wptr_q <= '0;
      count <= '0;
      head <= '0;
    end else begin
      mem_q <= mem_d;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      count <= cnt_d;
      head <= head_d;
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, synchronous imem with load port and prefetch FIFO feeding the decoder
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int IMEM_DEPTH = 256,
  parameter int FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            misalign_err_o,
  input  logic            imem_we_i,
  input  logic [XLEN-1:0] imem_waddr_i,
  input  logic [XLEN-1:0] imem_wdata_i
);
  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [XLEN-1:0] imem [IMEM_DEPTH];
  logic [XLEN-1:0] pc_q, pc_d, rd_addr, rd_pc_q, rdata_q;
  logic inflight_q, issue, misalign_q, err_d, pop, room, target_ok;
  fetch_state_t state_q, state_d;
  logic [CW-1:0] count;
  logic [2*XLEN-1:0] head;
  logic unused_waddr_bits;
  assign instr_valid_o = count != '0;
  assign pop = instr_valid_o && instr_ready_i;
  assign {instr_pc_o, instr_o} = head;
  assign misalign_err_o = misalign_q;
  assign target_ok = word_aligned(redirect_pc_i[1:0]);
  assign room = int'(count) - int'(pop) + int'(inflight_q) < FIFO_DEPTH;
  assign unused_waddr_bits = ^{imem_waddr_i[XLEN-1:IW+2], imem_waddr_i[1:0]};
  // next state, issue decision and next PC; a redirect overrides sequential fetch
  always_comb begin
    state_d = state_q;
    issue = 1'b0;
    rd_addr = pc_q;
    pc_d = pc_q;
    err_d = misalign_q;
    if (redirect_i) begin
      state_d = target_ok ? RUN : HALT;
      issue = target_ok;
      rd_addr = redirect_pc_i;
      pc_d = target_ok ? redirect_pc_i + XLEN'(4) : pc_q;
      err_d = !target_ok;
    end else if (state_q == RUN && room) begin
      issue = 1'b1;
      pc_d = pc_q + XLEN'(4);
    end
  end
  // control registers; reset also drops any read in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      rd_pc_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      inflight_q <= issue;
      rd_pc_q <= issue ? rd_addr : rd_pc_q;
      misalign_q <= err_d;
    end
  end
  // program-load write and synchronous read; same-word collisions return the old word
  always_ff @(posedge clk) begin
    if (imem_we_i) imem[imem_waddr_i[IW+1:2]] <= imem_wdata_i;
    if (issue) rdata_q <= imem[rd_addr[IW+1:2]];
  end
  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_q),
    .pop   (pop),
    .flush (redirect_i),
    .din   ({rd_pc_q, rdata_q}),
    .head  (head),
    .count (count)
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: random and directed fetch traffic checked against an instruction-stream model
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic instr_ready_i = 1'b0;
  logic imem_we_i = 1'b0;
  logic [31:0] imem_waddr_i = '0;
  logic [31:0] imem_wdata_i = '0;
  logic instr_valid_o, misalign_err_o;
  logic [31:0] instr_o, instr_pc_o;
  logic [31:0] mm [256];
  logic [31:0] exp_pc;
  logic halted, exp_err;
  int since, need;
  int total = 0;
  int bad = 0;

  instr_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .instr_valid_o  (instr_valid_o),
    .instr_ready_i  (instr_ready_i),
    .instr_o        (instr_o),
    .instr_pc_o     (instr_pc_o),
    .misalign_err_o (misalign_err_o),
    .imem_we_i      (imem_we_i),
    .imem_waddr_i   (imem_waddr_i),
    .imem_wdata_i   (imem_wdata_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // asserts reset asynchronously, reloads the program under reset, then releases
  task automatic do_reset();
    logic [31:0] wa;
    instr_ready_i = 1'b0;
    redirect_i = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_err", 32'(misalign_err_o), 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_pc", instr_pc_o, 32'd0);
    for (int i = 0; i < 256; i++) begin
      mm[i] = $urandom;
      wa = $urandom;
      wa[9:2] = i[7:0];
      imem_we_i = 1'b1;
      imem_waddr_i = wa;
      imem_wdata_i = mm[i];
      @(posedge clk);
      #1;
    end
    imem_we_i = 1'b0;
    reset = 1'b0;
    since = 0;
    need = 2;
    halted = 1'b0;
    exp_err = 1'b0;
    exp_pc = 32'h0;
  endtask

  // one clock: drive inputs, score any handshake, then check the post-edge outputs
  task automatic cycle(input logic rdy, input logic rd, input logic [31:0] rpc);
    logic hs, hold;
    logic [31:0] p_i, p_pc;
    instr_ready_i = rdy;
    redirect_i = rd;
    redirect_pc_i = rpc;
    hs = instr_valid_o && rdy;
    hold = instr_valid_o && !rdy && !rd;
    p_i = instr_o;
    p_pc = instr_pc_o;
    if (hs) begin
      check("acc_pc", instr_pc_o, exp_pc);
      check("acc_instr", instr_o, mm[exp_pc[9:2]]);
      exp_pc += 32'd4;
    end
    @(posedge clk);
    #1;
    redirect_i = 1'b0;
    imem_we_i = 1'b0;
    if (rd && rpc[1:0] == 2'b00) begin
      halted = 1'b0;
      exp_err = 1'b0;
      exp_pc = rpc;
      since = 0;
      need = 1;
    end else if (rd) begin
      halted = 1'b1;
      exp_err = 1'b1;
    end else begin
      since++;
    end
    check("valid", 32'(instr_valid_o), 32'(!halted && since >= need));
    check("err", 32'(misalign_err_o), 32'(exp_err));
    if (hold) begin
      check("hold_instr", instr_o, p_i);
      check("hold_pc", instr_pc_o, p_pc);
    end
  endtask

  initial begin
    logic [31:0] t, old_w, new_w;
    logic rdy, rd;
    #2;
    do_reset();
    repeat (8) cycle(1'b1, 1'b0, 32'h0);
    do_reset();
    repeat (7) cycle(1'b0, 1'b0, 32'h0);
    repeat (6) cycle(1'b1, 1'b0, 32'h0);
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h40);
    repeat (5) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h42);
    repeat (12) cycle(1'($urandom_range(0, 1)), 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h8);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h3FC);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);
    t = 32'h0000_0120;
    old_w = mm[t[9:2]];
    new_w = ~old_w;
    imem_we_i = 1'b1;
    imem_waddr_i = t;
    imem_wdata_i = new_w;
    cycle(1'b0, 1'b1, t);
    cycle(1'b0, 1'b0, 32'h0);
    check("rdw_old", instr_o, old_w);
    mm[t[9:2]] = new_w;
    cycle(1'b0, 1'b1, t);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);
    for (int n = 0; n < 1500; n++) begin
      rdy = $urandom_range(0, 3) != 0;
      rd = $urandom_range(0, halted ? 7 : 39) == 0;
      t = $urandom;
      t[1:0] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cycle(rdy, rd, t);
    end
    cycle(1'b1, 1'b1, 32'h100);
    repeat (3) cycle(1'b1, 1'b0, 32'h0);
    check("pre_rst_valid", 32'(instr_valid_o), 32'd1);
    do_reset();
    repeat (8) cycle(1'b1, 1'b0, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
